// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with a request/ack line memory port.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned LINE_BITS  = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
`ifdef DCACHE_STATS_EN
    input  logic                 mem_ack_i,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`else
    input  logic                 mem_ack_i
`endif
);

    localparam int unsigned NUM_LINES = 2 ** INDEX_BITS;
    localparam int unsigned TAG_BITS  = 32 - 5 - INDEX_BITS;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWback = 2'd1;
    localparam logic [1:0] StAlloc = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [NUM_LINES-1:0]  valid_q, dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0]  data_q [NUM_LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [2:0]            wsel;
    logic [LINE_BITS-1:0]  line;
    logic [31:0]           rd_word;
    logic                  hit;
    logic                  store_hit;
    logic                  refill;
    logic                  wb_done;
    logic                  stall_c;
    logic [31:0]           rdata_c;
    logic                  unused_addr_bits;

    assign idx              = cpu_addr_i[4+INDEX_BITS:5];
    assign tag              = cpu_addr_i[31:5+INDEX_BITS];
    assign wsel             = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];
    assign line             = data_q[idx];
    assign rd_word          = line[{wsel, 5'b0} +: 32];
    assign hit              = valid_q[idx] & (tag_q[idx] == tag);

    assign store_hit = (state_q == StIdle) & cpu_req_i & cpu_we_i & hit;
    assign refill    = (state_q == StAlloc) & mem_ack_i;
    assign wb_done   = (state_q == StWback) & mem_ack_i;

    always_comb begin
        state_d    = state_q;
        stall_c    = 1'b0;
        rdata_c    = 32'h0;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = 32'h0;
        mem_data_o = '0;
        case (state_q)
            StIdle: begin
                if (cpu_req_i && !hit) begin
                    stall_c = 1'b1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWback : StAlloc;
                end else if (cpu_req_i && !cpu_we_i) begin
                    rdata_c = rd_word;
                end
            end
            StWback: begin
                stall_c    = 1'b1;
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {tag_q[idx], idx, 5'b0};
                mem_data_o = line;
                if (mem_ack_i) begin
                    state_d = StAlloc;
                end
            end
            StAlloc: begin
                stall_c    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {cpu_addr_i[31:5], 5'b0};
                if (mem_ack_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset forces the CPU-facing outputs low before the FSM has seen a clock edge.
    assign cpu_stall_o = stall_c & ~rst_i;
    assign cpu_data_o  = rdata_c & {32{~rst_i}};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (refill) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (wb_done) begin
                dirty_q[idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (refill) begin
                tag_q[idx]  <= tag;
                data_q[idx] <= mem_data_i;
            end else if (store_hit) begin
                data_q[idx][{wsel, 5'b0} +: 32] <= cpu_data_i;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic retry_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_q    <= 1'b0;
            hit_cnt_o  <= 32'h0;
            miss_cnt_o <= 32'h0;
        end else begin
            retry_q <= refill;
            // The re-lookup right after a refill is part of the miss, not a fresh hit.
            if ((state_q == StIdle) && cpu_req_i && hit && !retry_q) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if ((state_q == StIdle) && (state_d != StIdle)) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
